// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Fetch-side bundle: PC control, imem request/response, IF/ID stage
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    logic        fetch_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        input  fetch_en,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    modport slave (
        output fetch_en,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch sequencer with redirect squash
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire          clk,
    input  wire          rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_pc,       w_pc_nxt;
    logic [31:0] r_req_pc,   w_req_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic [31:0] r_if_pc,    w_if_pc_nxt;
    logic        r_squash,   w_squash_nxt;
    logic        w_req_fire;
    state_t      w_resume;

    assign bus.imem_req_valid = (r_state == S_REQ) && bus.fetch_en && !bus.redirect_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = (r_state == S_HOLD);
    assign bus.if_instr       = r_if_instr;
    assign bus.if_pc          = r_if_pc;

    assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
    // Where to go once the current fetch slot is retired or abandoned
    assign w_resume   = bus.fetch_en ? S_REQ : S_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= 32'd0;
            r_squash   <= 1'b0;
            r_if_instr <= 32'd0;
            r_if_pc    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_pc_nxt   = r_req_pc;
        w_squash_nxt   = r_squash;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;

        if (bus.redirect_valid) begin
            w_pc_nxt = bus.redirect_pc;
            case (r_state)
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = w_resume;
                    end else begin
                        // Response still in flight: mark it for discard on arrival
                        w_squash_nxt = 1'b1;
                    end
                end
                S_HOLD:  w_state_nxt = w_resume;
                default: ;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.fetch_en) w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (w_req_fire) begin
                        w_req_pc_nxt = r_pc;
                        w_pc_nxt     = r_pc + 32'd4;
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = S_WAIT;
                    end else if (!bus.fetch_en) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (r_squash) begin
                            w_squash_nxt = 1'b0;
                            w_state_nxt  = w_resume;
                        end else begin
                            w_if_instr_nxt = bus.imem_rsp_data;
                            w_if_pc_nxt    = r_req_pc;
                            w_state_nxt    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.id_ready) w_state_nxt = w_resume;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the program counter and the instruction-memory request/response handshake, then presents one fetched instruction at a time to decode. It sits between the core's PC logic, the instruction memory port and the IF/ID boundary. It handles decode back-pressure, branch/jump redirects (including squashing in-flight fetches) and fetch enable/disable. At most one memory request is outstanding at any time.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_en  in  1  permits new fetch requests
- imem_req_valid  out  1  request to instruction memory (combinational from state/inputs)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address = current pc register
- imem_rsp_valid  in  1  response data valid (one per accepted request)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump/exception redirect, single-cycle pulse
- redirect_pc  in  32  redirect target
- if_valid  out  1  fetched instruction valid to decode
- if_instr  out  32  fetched instruction (registered)
- if_pc  out  32  address of if_instr (registered)
- id_ready  in  1  decode accepts if_instr this cycle

## Operation

- Registers: state, pc, req_pc (address of outstanding request), squash, if_valid, if_instr, if_pc.
- Reset: state=IDLE, pc=RESET_PC, req_pc=0, squash=0, if_valid=0, if_instr=0, if_pc=0.
- imem_req_valid = (state==REQ) & fetch_en & ~redirect_valid; imem_req_addr = pc.
- if_valid = 1 exactly when state==HOLD.
- IDLE: fetch_en=1 -> REQ.
- REQ: imem_req_valid & imem_req_ready -> req_pc<=pc, pc<=pc+4, squash<=0, go WAIT. If fetch_en=0 and no redirect -> IDLE. Otherwise stay.
- WAIT: imem_rsp_valid arriving with squash=0 and no redirect -> if_instr<=imem_rsp_data, if_pc<=req_pc, go HOLD. If squash=1 or redirect_valid is set that cycle -> response dropped, squash<=0, go REQ if fetch_en, else IDLE.
- HOLD: id_ready=1 -> handshake, go REQ if fetch_en, else IDLE. if_instr/if_pc stay stable while id_ready=0.
- Redirect (priority over all else), in any state: pc<=redirect_pc.
  - IDLE/REQ: no request is issued that cycle; state is unchanged (REQ stays REQ).
  - WAIT with no response that cycle: squash<=1, stay WAIT.
  - HOLD: held instruction discarded (if_valid=0 next cycle), go REQ if fetch_en, else IDLE, even if id_ready=1 that cycle.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0. No alignment check; redirect_pc is used verbatim.
- A response in IDLE/REQ/HOLD is a protocol violation. It is ignored.
- Reset mid-operation: all registers return to reset values immediately. Any later memory response is ignored by the IDLE rule above.

## Timing

- fetch_en rise at cycle t (from IDLE) -> imem_req_valid at t+1.
- Request accepted at cycle a -> earliest response at a+1.
- Response at cycle r -> if_valid=1 at r+1.
- Handshake at cycle h -> imem_req_valid at h+1.
- Zero-wait memory gives one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect at cycle d -> imem_req_addr=redirect_pc from d+1. The first post-redirect if_valid is no earlier than d+3.

## Test plan

- Reset then sequential fetch: RESET_PC=0x100, fetch_en=1, always-ready memory with 1-cycle response. Required: if_pc sequence 0x100, 0x104, 0x108, each with its matching if_instr, one every 3 cycles.
- Back-pressure: id_ready=0 for 5 cycles while in HOLD. Required: if_valid, if_instr and if_pc stable; no imem_req_valid until the cycle after id_ready=1.
- Squash: redirect to 0x2000 while WAIT for 0x104. Required: the 0x104 response is dropped, next request address is 0x2000, and the next if_pc is 0x2000.
- Redirect during HOLD with id_ready=1: required that the held instruction is not counted and the next if_pc is the redirect target.
- Wrap and memory stall: pc=0xFFFF_FFFC, imem_req_ready=0 for 3 cycles. Required: the request holds address 0xFFFF_FFFC, and the next request address is 0x0000_0000.
- Async reset asserted in WAIT, between clock edges. Required: outputs go to reset values immediately; a stale response after release produces no if_valid.
